alu_result_fifo: RTL and testbench

Downstream capture stage for the 32-bit ALU. It takes the ALU's registered result together with the opcode and operand sign bits that produced it, and derives zero, negative and signed-overflow flags. Result and flags are buffered in a small FIFO, and the block presents them to the consumer (register writeback or trace logic) over a valid/ready handshake. It also keeps an accepted-result counter and a sticky error for pushes attempted while the FIFO is full.

---
 rtl/alu_result_fifo.sv | 60 ++++++
 tb/tb_alu_result_fifo.sv | 138 +++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: derives zero/neg/overflow flags for ALU results and buffers them
// in a circular FIFO presented to the consumer over valid/ready.
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [31:0]      in_result,
    input  logic [3:0]       in_sel,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [3:0]       out_sel,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf,
    output logic [CNT_W-1:0] res_count,
    output logic             drop_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] full_cnt = (AW + 1)'(DEPTH);

    logic [38:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, ovf;

    assign in_ready  = (count != full_cnt) && rst_n;
    assign out_valid = count != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    // Signed-add overflow: operands share a sign that the result does not.
    assign ovf       = (in_sel == 4'b0011) && (in_a_msb == in_b_msb) && (in_result[31] != in_a_msb);
    assign {out_sel, out_ovf, out_neg, out_zero, out_result} = mem[rd_ptr];

    always_ff @(posedge clk)
        if (push)
            mem[wr_ptr] <= {in_sel, ovf, in_result[31], in_result == 32'h0, in_result};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            res_count <= '0;
            drop_err  <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(push);
            rd_ptr    <= rd_ptr + AW'(pop);
            count     <= count + (AW + 1)'(push) - (AW + 1)'(pop);
            res_count <= res_count + CNT_W'(push);
            drop_err  <= drop_err | (in_valid & ~in_ready);
        end
    end
endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: directed stimulus with a scoreboard queue; a negedge monitor
// checks every entry the consumer takes against the expected flagged result.
module tb_alu_result_fifo;
    logic        clk = 0, rst_n = 0, in_valid = 0, in_a_msb = 0, in_b_msb = 0, out_ready = 0;
    logic [31:0] in_result = 0;
    logic [3:0]  in_sel = 0;
    logic        in_ready, out_valid, out_zero, out_neg, out_ovf, drop_err;
    logic [31:0] out_result;
    logic [3:0]  out_sel;
    logic [15:0] res_count;

    logic [38:0] q[$];
    int          total = 0, passed = 0, n_push = 0;

    alu_result_fifo #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_result(in_result),
        .in_sel(in_sel), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_sel(out_sel), .out_zero(out_zero), .out_neg(out_neg), .out_ovf(out_ovf),
        .res_count(res_count), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor: one comparison per entry the consumer actually takes.
    always @(negedge clk)
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected_pop", 1, 0);
            else chk("head_entry", {out_sel, out_ovf, out_neg, out_zero, out_result}, q.pop_front());
        end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Flags z/n/o are hand-computed by the caller; entry goes to the scoreboard.
    task automatic do_push(input logic [31:0] r, input logic [3:0] s, input logic a, input logic b,
                           input logic z, input logic n, input logic o);
        in_valid = 1; in_result = r; in_sel = s; in_a_msb = a; in_b_msb = b;
        chk("in_ready_before_push", in_ready, 1);
        q.push_back({s, o, n, z, r});
        n_push++;
        tick();
        in_valid = 0;
    endtask

    initial begin
        // Reset held with in_valid asserted
        in_valid = 1; in_result = 32'h1234;
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_res_count", res_count, 0);
        chk("rst_drop_err", drop_err, 0);
        in_valid = 0; rst_n = 1; #1;
        chk("rel_in_ready", in_ready, 1);
        tick();
        chk("rel_out_valid", out_valid, 0);

        // Single zero push, 1-cycle latency, then pop
        do_push(32'h0, 4'b0000, 0, 0, 1, 0, 0);
        chk("single_out_valid", out_valid, 1);
        out_ready = 1;
        tick();
        chk("single_popped", out_valid, 0);

        // Flag derivation, back-to-back pushes with continuous pops
        do_push(32'h8000_0000, 4'b0011, 0, 0, 0, 1, 1);
        do_push(32'h8000_0000, 4'b0010, 0, 0, 0, 1, 0);
        do_push(32'h7FFF_FFFF, 4'b0011, 1, 0, 0, 0, 0);
        do_push(32'h0000_0001, 4'b0011, 1, 1, 0, 0, 1);
        do_push(32'hFFFF_FFFF, 4'b1111, 0, 0, 0, 1, 0);
        tick();
        chk("flags_drained", out_valid, 0);
        chk("flags_res_count", res_count, 16'(n_push));

        // Fill, drop attempt, drain
        out_ready = 0;
        for (int i = 1; i <= 4; i++) do_push(32'(i), 4'b0001, 0, 0, 0, 0, 0);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        chk("full_no_err_yet", drop_err, 0);
        in_valid = 1; in_result = 32'd5;
        tick();
        in_valid = 0;
        chk("drop_err_set", drop_err, 1);
        chk("drop_res_count", res_count, 16'(n_push));
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) chk("drain_in_ready", in_ready, 1);
        end
        chk("drain_empty", out_valid, 0);

        // Concurrent push/pop at occupancy 2 across pointer wrap
        out_ready = 0;
        do_push(32'd8, 4'b0011, 0, 0, 0, 0, 0);
        do_push(32'd9, 4'b0011, 0, 0, 0, 0, 0);
        out_ready = 1;
        for (int v = 10; v < 20; v++) do_push(32'(v), 4'b0011, 0, 0, 0, 0, 0);
        chk("wrap_res_count", res_count, 16'(n_push));
        chk("wrap_drop_err_sticky", drop_err, 1);
        tick();
        chk("wrap_one_left", out_valid, 1);
        tick();
        chk("wrap_empty", out_valid, 0);

        // Mid-operation reset discards buffered entries
        out_ready = 0;
        for (int i = 0; i < 3; i++) do_push(32'(30 + i), 4'b0000, 0, 0, 0, 0, 0);
        rst_n = 0;
        tick();
        q.delete();
        n_push = 0;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_res_count", res_count, 0);
        chk("mid_rst_drop_err", drop_err, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        rst_n = 1; #1;
        chk("mid_rel_in_ready", in_ready, 1);
        do_push(32'h0000_0028, 4'b0100, 1, 1, 0, 0, 0);
        out_ready = 1;
        tick();
        chk("mid_after_pop", out_valid, 0);
        chk("mid_res_count", res_count, 16'(n_push));
        chk("scoreboard_empty", q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
